// File: rtl/led_blink_sched_pkg.sv
// Shared types and helpers for the status-LED blink-code scheduler.
package led_sched_pkg;

  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // A zero blink count still shows one pulse so the request is visible.
  function automatic logic [CODE_W-1:0] code_eff(input logic [CODE_W-1:0] code);
    return (code == '0) ? CODE_W'(1) : code;
  endfunction

endpackage

// File: rtl/led_blink_sched_if.sv
// Requester/LED bundle between status sources and the blink scheduler.
import led_sched_pkg::*;

interface led_blink_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic                        en;
  logic [NUM_REQ-1:0]          req;
  logic [CODE_W*NUM_REQ-1:0]   code;
  logic                        led;
  logic [NUM_REQ-1:0]          grant;
  logic                        busy;
  logic                        done;

  modport master (output en, req, code, input led, grant, busy, done);
  modport slave  (input en, req, code, output led, grant, busy, done);
endinterface

// File: rtl/led_blink_sched_phase_tick.sv
// Phase timebase: free counter restarted by i_clr; o_tick marks the terminal
// cycle of a phase and o_pre_tick the cycle just before it.
module led_phase_tick #(
  parameter int unsigned PHASE_CYCLES = 5000000
) (
  input  logic i_clk,
  input  logic i_res,
  input  logic i_clr,
  output logic o_tick,
  output logic o_pre_tick
);

  localparam int unsigned CNT_W = $clog2(PHASE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PHASE_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (i_clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Flags are registered from the next count so they line up with cnt_q.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      cnt_q      <= '0;
      o_tick     <= 1'b0;
      o_pre_tick <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      o_tick     <= (cnt_d == CNT_LAST);
      o_pre_tick <= (cnt_d == CNT_PRE);
    end
  end

endmodule

// File: rtl/led_blink_sched.sv
// Status-LED blink-code scheduler: arbitrates requesters and plays ON/OFF/GAP.
// Build option: LED_BLINK_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module led_blink_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PHASE_CYCLES = 5000000,
  parameter int unsigned GAP_PHASES   = 4
) (
  input  logic              i_clk,
  input  logic              i_res,
  led_blink_sched_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned GAP_W = $clog2(GAP_PHASES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_PHASES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               led_d, busy_d, done_d;
  logic               tick, pre_tick, clr_c;
  logic [IDX_W-1:0]   start, win;
  logic               found;
  int unsigned        arb_idx;
  logic [CODE_W-1:0]  codes [NUM_REQ];

`ifdef LED_BLINK_SCHED_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
`endif

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_code
    assign codes[k] = bus.code[k*CODE_W +: CODE_W];
  end

  // First pending requester at or after the search start, wrapping once.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    arb_idx = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_idx = 32'(start) + i;
      if (arb_idx >= NUM_REQ) begin
        arb_idx = arb_idx - NUM_REQ;
      end
      if (!found && bus.req[IDX_W'(arb_idx)]) begin
        found = 1'b1;
        win   = IDX_W'(arb_idx);
      end
    end
  end

  led_phase_tick #(
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_tick (
    .i_clk      (i_clk),
    .i_res      (i_res),
    .i_clr      (clr_c),
    .o_tick     (tick),
    .o_pre_tick (pre_tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    grant_d = bus.grant;
    done_d  = 1'b0;
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif

    if (!bus.en) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      gap_d   = '0;
      grant_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_d = ST_ON;
            grant_d = NUM_REQ'(1) << win;
            rem_d   = code_eff(codes[win]);
            gap_d   = '0;
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
            ptr_d   = (win == IDX_LAST) ? '0 : win + IDX_W'(1);
`endif
          end
        end
        ST_ON: begin
          if (tick) begin
            rem_d   = rem_q - CODE_W'(1);
            state_d = (rem_d == '0) ? ST_GAP : ST_OFF;
          end
        end
        ST_OFF: begin
          if (tick) begin
            state_d = ST_ON;
          end
        end
        ST_GAP: begin
          // Raise done one cycle early so the registered pulse hits the last cycle.
          if (pre_tick && (gap_q == GAP_LAST)) begin
            done_d = 1'b1;
          end
          if (tick) begin
            if (gap_q == GAP_LAST) begin
              state_d = ST_IDLE;
              gap_d   = '0;
              grant_d = '0;
            end else begin
              gap_d = gap_q + GAP_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      endcase
    end

    clr_c  = (state_d != state_q) || (state_d == ST_IDLE);
    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      gap_q     <= '0;
      bus.led   <= 1'b0;
      bus.grant <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      bus.led   <= led_d;
      bus.grant <= grant_d;
      bus.busy  <= busy_d;
      bus.done  <= done_d;
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

endmodule
